// File: rtl/mvau_inp_buf_ctrl.sv
// ============================================================================
// Module   : mvau_inp_buf_ctrl
// Brief    : MVAU input activation buffer sequencer. Writes and bypasses one
//            input vector on the first neuron fold, then replays it from the
//            buffer for the remaining folds.
//            Optional: define MVAU_INP_CTRL_VEC_CNT_EN to add o_vec_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvau_inp_buf_ctrl #(
  parameter int MATRIX_W = 20,
  parameter int MATRIX_H = 20,
  parameter int SIMD     = 2,
  parameter int PE       = 2,
  parameter int BUF_LEN  = MATRIX_W / SIMD,
  parameter int BUF_ADDR = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_in_v,
  output logic                o_in_rdy,
  input  logic                i_out_rdy,
  output logic                o_out_v,
  output logic                o_buf_wr_en,
  output logic                o_buf_rd_en,
  output logic [BUF_ADDR-1:0] o_buf_addr,
  output logic                o_sf_last,
  output logic                o_nf_last
`ifdef MVAU_INP_CTRL_VEC_CNT_EN
  ,
  output logic [31:0]         o_vec_cnt
`endif
);

  localparam int c_SF   = BUF_LEN;
  localparam int c_NF   = MATRIX_H / PE;
  localparam int c_NF_W = (c_NF > 1) ? $clog2(c_NF) : 1;

  localparam logic [BUF_ADDR-1:0] c_SF_MAX = BUF_ADDR'(c_SF - 1);
  localparam logic [c_NF_W-1:0]   c_NF_MAX = c_NF_W'(c_NF - 1);

  typedef enum logic [0:0] {
    S_WRITE = 1'b0,
    S_READ  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BUF_ADDR-1:0] r_sf_cnt;
  logic [BUF_ADDR-1:0] w_sf_nxt;
  logic [c_NF_W-1:0]   r_nf_cnt;
  logic [c_NF_W-1:0]   w_nf_nxt;

  logic w_in_rdy;
  logic w_out_v;
  logic w_wr_en;
  logic w_rd_en;
  logic w_sf_last;
  logic w_nf_last;
  logic w_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WRITE;
      r_sf_cnt <= '0;
      r_nf_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sf_cnt <= w_sf_nxt;
      r_nf_cnt <= w_nf_nxt;
    end
  end

  always_comb begin
    w_in_rdy    = 1'b0;
    w_out_v     = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_state_nxt = r_state;
    w_sf_nxt    = r_sf_cnt;
    w_nf_nxt    = r_nf_cnt;
    w_sf_last   = (r_sf_cnt == c_SF_MAX);
    w_nf_last   = (r_nf_cnt == c_NF_MAX);

    case (r_state)
      S_WRITE: begin
        // Bypass: the datapath sees the stream word while the buffer captures it
        w_in_rdy = i_out_rdy;
        w_out_v  = i_in_v;
        w_wr_en  = i_in_v & i_out_rdy;
      end
      S_READ: begin
        w_out_v = 1'b1;
        w_rd_en = 1'b1;
      end
      default: begin
        w_state_nxt = S_WRITE;
      end
    endcase

    w_xfer = w_out_v & i_out_rdy;

    if (w_xfer) begin
      if (w_sf_last) begin
        w_sf_nxt = '0;
        if (w_nf_last) begin
          w_nf_nxt    = '0;
          w_state_nxt = S_WRITE;
        end else begin
          w_nf_nxt    = r_nf_cnt + c_NF_W'(1);
          w_state_nxt = S_READ;
        end
      end else begin
        w_sf_nxt = r_sf_cnt + BUF_ADDR'(1);
      end
    end
  end

  assign o_in_rdy    = w_in_rdy;
  assign o_out_v     = w_out_v;
  assign o_buf_wr_en = w_wr_en;
  assign o_buf_rd_en = w_rd_en;
  assign o_buf_addr  = r_sf_cnt;
  assign o_sf_last   = w_sf_last;
  assign o_nf_last   = w_nf_last;

`ifdef MVAU_INP_CTRL_VEC_CNT_EN
  logic [31:0] r_vec_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt <= '0;
    end else if (w_xfer && w_sf_last && w_nf_last) begin
      r_vec_cnt <= r_vec_cnt + 32'd1;
    end
  end

  assign o_vec_cnt = r_vec_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mvau_inp_buf_ctrl.sv
// ============================================================================
// Module   : tb_mvau_inp_buf_ctrl
// Brief    : Self-checking bench for mvau_inp_buf_ctrl (SF=4, NF=3 and NF=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvau_inp_buf_ctrl;

  typedef struct {
    logic       in_v;
    logic       out_rdy;
    logic [7:0] exp;   // {in_rdy, out_v, wr_en, rd_en, addr[1:0], sf_last, nf_last}
  } vec_t;

  logic clk;
  logic rst_n;

  logic       in_v0, out_rdy0;
  logic       in_rdy0, out_v0, wr0, rd0, sfl0, nfl0;
  logic [1:0] addr0;

  logic       in_v1, out_rdy1;
  logic       in_rdy1, out_v1, wr1, rd1, sfl1, nfl1;
  logic [1:0] addr1;

`ifdef MVAU_INP_CTRL_VEC_CNT_EN
  logic [31:0] vec_cnt0;
  logic [31:0] vec_cnt1;
`endif

  int checks;
  int failures;
  vec_t exp_q[$];

  mvau_inp_buf_ctrl #(
    .MATRIX_W(8), .MATRIX_H(6), .SIMD(2), .PE(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_v(in_v0), .o_in_rdy(in_rdy0),
    .i_out_rdy(out_rdy0), .o_out_v(out_v0),
    .o_buf_wr_en(wr0), .o_buf_rd_en(rd0), .o_buf_addr(addr0),
    .o_sf_last(sfl0), .o_nf_last(nfl0)
`ifdef MVAU_INP_CTRL_VEC_CNT_EN
    , .o_vec_cnt(vec_cnt0)
`endif
  );

  mvau_inp_buf_ctrl #(
    .MATRIX_W(8), .MATRIX_H(2), .SIMD(2), .PE(2)
  ) u_dut_nf1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_v(in_v1), .o_in_rdy(in_rdy1),
    .i_out_rdy(out_rdy1), .o_out_v(out_v1),
    .o_buf_wr_en(wr1), .o_buf_rd_en(rd1), .o_buf_addr(addr1),
    .o_sf_last(sfl1), .o_nf_last(nfl1)
`ifdef MVAU_INP_CTRL_VEC_CNT_EN
    , .o_vec_cnt(vec_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for vector position t (0..11): t<4 is the write/bypass fold.
  function automatic logic [7:0] model(input int t, input logic iv, input logic ordy);
    logic [1:0] a;
    a = 2'(t % 4);
    if (t < 4)
      return {ordy, iv, iv & ordy, 1'b0, a, (a == 2'd3), 1'b0};
    return {1'b0, 1'b1, 1'b0, 1'b1, a, (a == 2'd3), (t >= 8)};
  endfunction

  function automatic logic [7:0] model_nf1(input int t, input logic iv, input logic ordy);
    logic [1:0] a;
    a = 2'(t % 4);
    return {ordy, iv, iv & ordy, 1'b0, a, (a == 2'd3), 1'b1};
  endfunction

  task automatic compare(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {rdy,v,wr,rd,addr,sfl,nfl}=%b required %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic pop_check(input string nm, input int dut);
    vec_t e;
    logic [7:0] got;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got none required entry", nm);
      return;
    end
    e = exp_q.pop_front();
    got = (dut == 0) ? {in_rdy0, out_v0, wr0, rd0, addr0, sfl0, nfl0}
                     : {in_rdy1, out_v1, wr1, rd1, addr1, sfl1, nfl1};
    compare(nm, got, e.exp);
  endtask

  // Drive one cycle after posedge, check at negedge, return at next posedge+1.
  task automatic apply(input string nm, input int dut, input vec_t v);
    if (dut == 0) begin
      in_v0 = v.in_v; out_rdy0 = v.out_rdy;
    end else begin
      in_v1 = v.in_v; out_rdy1 = v.out_rdy;
    end
    exp_q.push_back(v);
    @(negedge clk);
    pop_check(nm, dut);
    @(posedge clk);
    #1;
  endtask

  // Runs one vector on the NF=3 DUT up to stop_t transfers, with optional
  // in_v gaps in the write fold and a 3-cycle stall at position stall_at.
  task automatic run_vec(input string nm, input int stop_t, input bit gap, input int stall_at);
    int t = 0;
    int stalls = 0;
    int cyc = 0;
    vec_t v;
    while (t < stop_t && cyc < 100) begin
      v.in_v    = (gap && t < 4) ? cyc[0] : 1'b1;
      v.out_rdy = 1'b1;
      if (t == stall_at && stalls < 3) begin
        v.out_rdy = 1'b0;
        stalls++;
      end
      v.exp = model(t, v.in_v, v.out_rdy);
      apply(nm, 0, v);
      if (v.exp[6] && v.out_rdy) t++;
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s: cycle budget expired got t=%0d required %0d", nm, t, stop_t);
    end
  endtask

  vec_t tbl[24];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_v0 = 1'b0; out_rdy0 = 1'b0;
    in_v1 = 1'b0; out_rdy1 = 1'b0;

    // Vectors A then B back-to-back, continuous in_v and out_rdy
    for (int i = 0; i < 24; i++) begin
      tbl[i].in_v    = 1'b1;
      tbl[i].out_rdy = 1'b1;
      tbl[i].exp     = model(i % 12, 1'b1, 1'b1);
    end

    #2;
    compare("reset_rdy_low", {in_rdy0, out_v0, wr0, rd0, addr0, sfl0, nfl0}, 8'b0000_0000);
    out_rdy0 = 1'b1;
    #1;
    compare("reset_rdy_high", {in_rdy0, out_v0, wr0, rd0, addr0, sfl0, nfl0}, 8'b1000_0000);
    compare("reset_nf1", {in_rdy1, out_v1, wr1, rd1, addr1, sfl1, nfl1}, 8'b0000_0001);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++)
      apply((i < 12) ? "vecA" : "vecB", 0, tbl[i]);

    run_vec("stall", 12, 1'b0, 6);
    run_vec("gap", 12, 1'b1, -1);

    // Partial vector: 4 writes plus 2 replays leaves nf_cnt=1, sf_cnt=2
    run_vec("pre_rst", 6, 1'b0, -1);
    in_v0 = 1'b0;
    out_rdy0 = 1'b1;
    #1;
    compare("mid_replay", {in_rdy0, out_v0, wr0, rd0, addr0, sfl0, nfl0}, 8'b0101_1000);
    #2 rst_n = 1'b0;
    #1;
    compare("async_rst", {in_rdy0, out_v0, wr0, rd0, addr0, sfl0, nfl0}, 8'b1000_0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec("post_rst", 12, 1'b0, -1);

    in_v0 = 1'b0;
    out_rdy0 = 1'b0;
`ifdef MVAU_INP_CTRL_VEC_CNT_EN
    compare("nf1_vec_cnt0", vec_cnt1[7:0], 8'd0);
`endif
    // NF=1: 20 transfers with in_v gaps and out_rdy drops
    begin
      int t = 0;
      int cyc = 0;
      vec_t v;
      while (t < 20 && cyc < 200) begin
        v.in_v    = (cyc % 3) != 2;
        v.out_rdy = (cyc % 5) != 4;
        v.exp     = model_nf1(t, v.in_v, v.out_rdy);
        apply("nf1", 1, v);
        if (v.in_v && v.out_rdy) t++;
        cyc++;
      end
      if (cyc >= 200) begin
        checks++;
        failures++;
        $display("FAIL nf1_budget: got t=%0d required 20", t);
      end
    end
`ifdef MVAU_INP_CTRL_VEC_CNT_EN
    compare("nf1_vec_cnt5", vec_cnt1[7:0], 8'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mvau_inp_buf_ctrl.md
Name: mvau_inp_buf_ctrl

Overview:
- Sequencer for the MVAU input activation buffer.
- Accepts one input vector as SF = MatrixW/SIMD stream words. During the first neuron fold it writes each word to the buffer and bypasses it to the datapath.
- Replays the stored vector from the buffer for the remaining NF-1 = MatrixH/PE - 1 neuron folds.
- Drives the buffer's write_en, read_en and addr, and handles input/output stream handshakes.

Parameters:
- MatrixW, 20, lowered weight matrix width (Kernel^2*IFMCh); must be a multiple of SIMD
- MatrixH, 20, weight matrix height (OFMCh); must be a multiple of PE
- SIMD, 2, input words per cycle
- PE, 2, processing elements
- BUF_LEN, MatrixW/SIMD, buffer depth (= SF)
- BUF_ADDR, $clog2(BUF_LEN) (minimum 1), buffer address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_v  in  1  input stream word valid
- in_rdy  out  1  controller accepts input word
- out_rdy  in  1  datapath can consume a word this cycle
- out_v  out  1  word on buffer output is valid for datapath
- buf_wr_en  out  1  to buffer write_en
- buf_rd_en  out  1  to buffer read_en; 0 selects bypass of in
- buf_addr  out  BUF_ADDR  to buffer addr, shared by read and write
- sf_last  out  1  current output word is last of its fold (sf_cnt==SF-1)
- nf_last  out  1  current fold is last neuron fold (nf_cnt==NF-1)

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk.
- On reset: state=WRITE, sf_cnt=0, nf_cnt=0.
- Reset values of outputs: in_rdy=out_rdy-gated (0 while out_rdy=0), out_v=0, buf_wr_en=0, buf_rd_en=0, buf_addr=0, sf_last=0 (SF>1), nf_last=0 (NF>1).
- Reset mid-vector abandons the partial vector. The next accepted word is treated as word 0 of a new vector.
- State WRITE:
  - in_rdy=out_rdy, out_v=in_v, buf_rd_en=0, buf_addr=sf_cnt.
  - buf_wr_en = in_v & out_rdy. Same-cycle write and bypass; the buffer latches the word at the clock edge.
- State READ:
  - in_rdy=0, buf_wr_en=0, buf_rd_en=1, buf_addr=sf_cnt.
  - out_v=1, because the buffer read is combinational.
- Transfer fires when out_v & out_rdy.
- On each transfer, sf_cnt increments. At SF-1 it wraps to 0 and nf_cnt increments.
- When nf_cnt==NF-1 and sf_cnt==SF-1, nf_cnt wraps to 0 and state goes to WRITE.
- After the first fold, WRITE goes to READ when SF-1 is reached and NF>1.
- NF=1: the controller stays in WRITE permanently; pure bypass plus write.
- SF=1: every transfer ends a fold; buf_addr is constantly 0.
- out_rdy=0 freezes all counters and state. Addresses and enables hold, so the buffer output stays stable.
- in_v deasserted in WRITE: no write, no count; out_v=0.
- No throughput bubbles: the first READ word is issued the cycle after the last WRITE transfer. The first WRITE word of the next vector can transfer the cycle after the final READ transfer.
- Latency is 0 cycles input→output in WRITE (combinational bypass). in_rdy depends combinationally on out_rdy only, never on in_v.
- Counter widths: sf_cnt BUF_ADDR bits, nf_cnt $clog2(NF) (minimum 1) bits. Comparisons are against the exact constants SF-1 and NF-1, never overflow-based.

Optional Feature:
- Macro: MVAU_INP_CTRL_VEC_CNT_EN.
- Defined: adds output port vec_cnt [31:0].
  - Reset to 0; increments by 1 on each final transfer of a vector (nf_last & sf_last & transfer).
  - Wraps modulo 2^32.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan (MatrixW=8, SIMD=2 → SF=4; MatrixH=6, PE=2 → NF=3, unless stated):
- Reset then stream words A0..A3 with out_rdy=1:
  - buf_wr_en=1 at addr 0,1,2,3, out_v follows in_v, buf_rd_en=0.
  - Next 8 cycles: in_rdy=0, buf_rd_en=1, addr 0,1,2,3,0,1,2,3.
  - sf_last on addr 3; nf_last during the final 4 cycles.
- Back-to-back vectors A then B with in_v=1 continuously:
  - B0 accepted the cycle after the final A replay word.
  - Exactly 12 transfers per vector, no idle cycles.
- Toggle out_rdy=0 for 3 cycles mid-replay at addr 2:
  - buf_addr holds 2, counters frozen, then resumes 2,3.
  - Output sequence identical to the unstalled run.
- in_v gapped, one word every other cycle, in WRITE:
  - buf_wr_en only on valid cycles, addresses still 0..3 contiguous, out_v=0 in gaps.
- Assert rst_n=0 asynchronously mid-replay (nf_cnt=1, sf_cnt=2):
  - Outputs drop to reset values immediately without waiting for clk; next accepted word written to addr 0.
- MatrixH=2, PE=2 (NF=1):
  - buf_rd_en never asserts; in_rdy=out_rdy throughout.
  - With MVAU_INP_CTRL_VEC_CNT_EN, vec_cnt reads 5 after 20 transfers.
